// File: rtl/itof_pipe.sv
// Pipelined integer to IEEE-754 single-precision converter with valid/ready flow control.
// Three stages: sign/magnitude, normalise, round/pack; one conversion per cycle.
module itof_pipe #(
   parameter int unsigned IW  = 32,
   parameter int unsigned TW  = 4,
   parameter bit          RNE = 1'b1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [IW-1:0] x,
   input  logic          is_signed,
   input  logic [TW-1:0] tag_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   y,
   output logic [TW-1:0] tag_out
);

   localparam int unsigned LzW = $clog2(IW);
   localparam int unsigned FW  = IW - 1;

   logic          s1_valid_q, s1_valid_d;
   logic          s1_sign_q, s1_sign_d;
   logic [IW-1:0] s1_mag_q, s1_mag_d;
   logic [TW-1:0] s1_tag_q, s1_tag_d;

   logic           s2_valid_q, s2_valid_d;
   logic           s2_sign_q, s2_sign_d;
   logic           s2_zero_q, s2_zero_d;
   logic [LzW-1:0] s2_lz_q, s2_lz_d;
   logic [FW-1:0]  s2_frac_q, s2_frac_d;
   logic [TW-1:0]  s2_tag_q, s2_tag_d;

   logic          out_valid_q, out_valid_d;
   logic [31:0]   y_q, y_d;
   logic [TW-1:0] tag_q, tag_d;

   logic out_adv, s2_ready, s1_ready;

   // Readiness ripples back from out_ready only; in_valid never feeds in_ready.
   assign out_adv  = !out_valid_q | out_ready;
   assign s2_ready = !s2_valid_q | out_adv;
   assign s1_ready = !s1_valid_q | s2_ready;
   assign in_ready = s1_ready;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_mag_d   = s1_mag_q;
      s1_tag_d   = s1_tag_q;
      if (s1_ready) s1_valid_d = in_valid;
      if (in_valid && s1_ready) begin
         s1_sign_d = is_signed & x[IW-1];
         s1_mag_d  = s1_sign_d ? (~x + 1'b1) : x;
         s1_tag_d  = tag_in;
      end
   end

   logic [LzW-1:0] lz;

   always_comb begin
      lz = '0;
      for (int i = 0; i < IW; i++) begin
         if (s1_mag_q[i]) lz = LzW'(IW - 1 - i);
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_sign_d  = s2_sign_q;
      s2_zero_d  = s2_zero_q;
      s2_lz_d    = s2_lz_q;
      s2_frac_d  = s2_frac_q;
      s2_tag_d   = s2_tag_q;
      if (s2_ready) s2_valid_d = s1_valid_q;
      if (s1_valid_q && s2_ready) begin
         s2_sign_d = s1_sign_q;
         s2_zero_d = ~|s1_mag_q;
         s2_lz_d   = lz;
         // Leading one is implicit; keep only the bits below it.
         s2_frac_d = FW'(s1_mag_q << lz);
         s2_tag_d  = s1_tag_q;
      end
   end

   logic [22:0] man, man_rnd;
   logic        round_up, carry;
   logic [7:0]  exp_f;

   if (IW <= 24) begin : g_exact
      assign man      = 23'(s2_frac_q) << (24 - IW);
      assign round_up = 1'b0;
   end else begin : g_round
      logic [FW:0] ext;
      assign ext = {s2_frac_q, 1'b0};
      assign man = ext[FW -: 23];
      if (RNE) begin : g_rne
         logic guard, sticky;
         assign guard    = ext[FW-23];
         assign sticky   = |ext[FW-24:0];
         assign round_up = guard & (sticky | man[0]);
      end else begin : g_trunc
         logic unused_low;
         assign unused_low = ^ext[FW-23:0];
         assign round_up   = 1'b0;
      end
   end

   // An all-ones mantissa wraps to zero and bumps the exponent.
   assign {carry, man_rnd} = {1'b0, man} + 24'(round_up);
   assign exp_f = 8'(126 + IW) - 8'(s2_lz_q) + {7'd0, carry};

   always_comb begin
      out_valid_d = out_adv ? s2_valid_q : out_valid_q;
      y_d         = y_q;
      tag_d       = tag_q;
      if (s2_valid_q && out_adv) begin
         y_d   = s2_zero_q ? 32'h0 : {s2_sign_q, exp_f, man_rnd};
         tag_d = s2_tag_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_mag_q    <= '0;
         s1_tag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_sign_q   <= 1'b0;
         s2_zero_q   <= 1'b0;
         s2_lz_q     <= '0;
         s2_frac_q   <= '0;
         s2_tag_q    <= '0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         tag_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_mag_q    <= s1_mag_d;
         s1_tag_q    <= s1_tag_d;
         s2_valid_q  <= s2_valid_d;
         s2_sign_q   <= s2_sign_d;
         s2_zero_q   <= s2_zero_d;
         s2_lz_q     <= s2_lz_d;
         s2_frac_q   <= s2_frac_d;
         s2_tag_q    <= s2_tag_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         tag_q       <= tag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign tag_out   = tag_q;

endmodule

// File: tb/tb_itof_pipe.sv
// Scoreboard bench for itof_pipe: directed values, backpressure stream, reset flush,
// plus side instances for truncation and 16/64-bit input widths.
module tb_itof_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic        in_valid, in_ready, is_signed, out_valid, out_ready;
   logic [31:0] x, y;
   logic [3:0]  tag_in, tag_out;

   logic        aux_valid;
   logic [3:0]  aux_tag;
   logic        a_rdy, b_rdy, c_rdy, va, vb, vc, sa, sb, sc;
   logic [31:0] xa, ya, yb, yc;
   logic [15:0] xb;
   logic [63:0] xc;
   logic [3:0]  ta, tb, tc;

   itof_pipe #(.IW(32), .TW(4), .RNE(1'b1)) u_dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .x(x),
      .is_signed(is_signed), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .tag_out(tag_out)
   );
   itof_pipe #(.IW(32), .TW(4), .RNE(1'b0)) u_trunc (
      .clk(clk), .rstn(rstn), .in_valid(aux_valid), .in_ready(a_rdy), .x(xa),
      .is_signed(sa), .tag_in(aux_tag), .out_valid(va), .out_ready(1'b1), .y(ya), .tag_out(ta)
   );
   itof_pipe #(.IW(16), .TW(4), .RNE(1'b1)) u_iw16 (
      .clk(clk), .rstn(rstn), .in_valid(aux_valid), .in_ready(b_rdy), .x(xb),
      .is_signed(sb), .tag_in(aux_tag), .out_valid(vb), .out_ready(1'b1), .y(yb), .tag_out(tb)
   );
   itof_pipe #(.IW(64), .TW(4), .RNE(1'b1)) u_iw64 (
      .clk(clk), .rstn(rstn), .in_valid(aux_valid), .in_ready(c_rdy), .x(xc),
      .is_signed(sc), .tag_in(aux_tag), .out_valid(vc), .out_ready(1'b1), .y(yc), .tag_out(tc)
   );

   typedef struct {
      logic [3:0]  tag;
      logic [31:0] y;
      int          t;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          step_n = 0;
   bit          chk_lat = 1'b0;
   logic [31:0] cur_y;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_y;
   logic [3:0]  prev_tag;

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Independent reference: find the MSB, shift, round on the discarded remainder.
   function automatic logic [31:0] ref_itof(input logic [63:0] xin, input int iw, input bit sgn,
                                            input bit rne);
      logic [63:0] mask, xv, mag, kept, rem, half;
      logic [31:0] e;
      bit          neg;
      int          p, sh;
      mask = (iw == 64) ? '1 : ((64'd1 << iw) - 64'd1);
      xv   = xin & mask;
      neg  = sgn && xv[iw-1];
      mag  = neg ? ((~xv + 64'd1) & mask) : xv;
      if (mag == 64'd0) return 32'h0;
      p = 63;
      while (!mag[p]) p--;
      e = 32'(127 + p);
      if (p <= 23) kept = mag << (23 - p);
      else begin
         sh   = p - 23;
         kept = mag >> sh;
         rem  = mag & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         if (rne && (rem > half || (rem == half && kept[0]))) kept = kept + 64'd1;
         if (kept[24]) begin
            kept = kept >> 1;
            e    = e + 32'd1;
         end
      end
      return {neg, e[7:0], kept[22:0]};
   endfunction

   // One clock: sample at negedge, update scoreboard, return at posedge+1.
   task automatic cycle(output bit acc);
      exp_t e;
      @(negedge clk);
      step_n++;
      check_eq("in_ready", in_ready, !(sb_q.size() == 3 && !out_ready));
      if (prev_stall) begin
         check_eq("stall_valid", out_valid, 1);
         check_eq("stall_y", y, prev_y);
         check_eq("stall_tag", tag_out, prev_tag);
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) check_eq("extra_out", out_valid, 0);
         else begin
            e = sb_q.pop_front();
            check_eq("y", y, e.y);
            check_eq("tag", tag_out, e.tag);
            if (chk_lat) check_eq("latency", step_n - e.t, 3);
         end
      end
      if (acc) sb_q.push_back('{tag: tag_in, y: cur_y, t: step_n});
      prev_stall = out_valid && !out_ready;
      prev_y     = y;
      prev_tag   = tag_out;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] xv, input bit sg, input logic [3:0] tg,
                       input logic [31:0] ye);
      bit acc = 1'b0;
      in_valid  = 1'b1;
      x         = xv;
      is_signed = sg;
      tag_in    = tg;
      cur_y     = ye;
      for (int i = 0; i < 50 && !acc; i++) cycle(acc);
      if (!acc) check_eq("send_accept", acc, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain(input bit rnd);
      bit acc;
      for (int i = 0; i < 300 && sb_q.size() != 0; i++) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         cycle(acc);
      end
      check_eq("drain_empty", sb_q.size(), 0);
      out_ready = 1'b1;
   endtask

   task automatic set_op(input int k);
      logic [31:0] xv;
      bit          sg;
      xv        = $urandom;
      sg        = 1'($urandom_range(0, 1));
      x         = xv;
      is_signed = sg;
      tag_in    = 4'(k);
      cur_y     = ref_itof({32'd0, xv}, 32, sg, 1'b1);
   endtask

   task automatic run_aux(input logic [31:0] a, input bit a_s, input logic [31:0] ea,
                          input logic [15:0] b, input bit b_s, input logic [31:0] eb,
                          input logic [63:0] c, input bit c_s, input logic [31:0] ec);
      bit got = 1'b0;
      xa = a; sa = a_s; xb = b; sb = b_s; xc = c; sc = c_s;
      aux_tag   = aux_tag + 4'd1;
      aux_valid = 1'b1;
      @(negedge clk);
      check_eq("aux_ready", {a_rdy, b_rdy, c_rdy}, 3'b111);
      @(posedge clk);
      #1;
      aux_valid = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         got = va;
      end
      check_eq("aux_valid", {va, vb, vc}, 3'b111);
      check_eq("trunc_y", ya, ea);
      check_eq("iw16_y", yb, eb);
      check_eq("iw64_y", yc, ec);
      check_eq("aux_tag", {ta, tb, tc}, {3{aux_tag}});
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit          acc;
      int          k;
      logic [31:0] ra;
      logic [15:0] rb;
      logic [63:0] rc;
      bit          s0, s1, s2;

      rstn = 1'b0; in_valid = 1'b0; x = '0; is_signed = 1'b0; tag_in = '0; out_ready = 1'b1;
      aux_valid = 1'b0; aux_tag = '0; xa = '0; xb = '0; xc = '0; sa = 1'b0; sb = 1'b0;
      sc = 1'b0; cur_y = '0;
      #12;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_y", y, 0);
      check_eq("rst_tag", tag_out, 0);
      check_eq("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Directed values, back to back at full rate.
      chk_lat = 1'b1;
      send(32'h0000_0001, 1'b1, 4'd1, 32'h3F80_0000);
      send(32'hFFFF_FFFF, 1'b1, 4'd2, 32'hBF80_0000);
      send(32'h0000_0000, 1'b1, 4'd3, 32'h0000_0000);
      send(32'h8000_0000, 1'b1, 4'd4, 32'hCF00_0000);
      send(32'h7FFF_FFFF, 1'b1, 4'd5, 32'h4F00_0000);
      send(32'd16777217,  1'b1, 4'd6, 32'h4B80_0000);
      send(32'd16777219,  1'b1, 4'd7, 32'h4B80_0002);
      send(32'hFFFF_FFFF, 1'b0, 4'd8, 32'h4F80_0000);
      send(32'h0000_0000, 1'b0, 4'd9, 32'h0000_0000);
      drain(1'b0);
      chk_lat = 1'b0;

      // Backpressure stream: tags 0..7, output stalled at first so the pipe fills.
      k = 0;
      in_valid = 1'b1;
      set_op(0);
      for (int i = 0; i < 300 && k < 8; i++) begin
         out_ready = (i < 5) ? 1'b0 : 1'($urandom_range(0, 1));
         cycle(acc);
         if (acc) begin
            k++;
            if (k < 8) set_op(k);
         end
      end
      in_valid = 1'b0;
      check_eq("stream_sent", k, 8);
      drain(1'b1);

      // Side instances: truncation, 16-bit and 64-bit widths.
      run_aux(32'h7FFF_FFFF, 1'b1, 32'h4EFF_FFFF, 16'h8000, 1'b1, 32'hC700_0000,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'h5F80_0000);
      run_aux(32'h8000_0001, 1'b0, 32'h4F00_0000, 16'hFFFF, 1'b0, 32'h477F_FF00,
              64'h8000_0000_0000_0000, 1'b1, 32'hDF00_0000);
      for (int i = 0; i < 4; i++) begin
         ra = $urandom; rb = 16'($urandom); rc = {$urandom, $urandom};
         s0 = 1'($urandom_range(0, 1)); s1 = 1'($urandom_range(0, 1));
         s2 = 1'($urandom_range(0, 1));
         run_aux(ra, s0, ref_itof({32'd0, ra}, 32, s0, 1'b0),
                 rb, s1, ref_itof({48'd0, rb}, 16, s1, 1'b1),
                 rc, s2, ref_itof(rc, 64, s2, 1'b1));
      end

      // Reset with two operations in flight.
      out_ready = 1'b0;
      send(32'd100, 1'b1, 4'hA, 32'h42C8_0000);
      send(32'd200, 1'b1, 4'hB, 32'h4348_0000);
      cycle(acc);
      cycle(acc);
      #2;
      rstn = 1'b0;
      #1;
      check_eq("flush_out_valid", out_valid, 0);
      check_eq("flush_y", y, 0);
      check_eq("flush_tag", tag_out, 0);
      sb_q.delete();
      prev_stall = 1'b0;
      out_ready  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk_lat = 1'b1;
      send(32'd2, 1'b1, 4'h3, 32'h4000_0000);
      drain(1'b0);
      for (int i = 0; i < 6; i++) cycle(acc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
